// File: rtl/xor2_share_arb.sv
// xor2_share_arb
// Round-robin sequencer that time-shares one external XOR2 gate among NREQ
// requesters. One operand pair is accepted per transaction. It is driven onto
// the gate through registers, held for SETTLE cycles, and then the gate output
// is sampled. The result is returned tagged with the owning requester's index.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  per-requester request valid           [NREQ]
//   req_a      per-requester operand A (bit i = req i) [NREQ]
//   req_b      per-requester operand B               [NREQ]
//   req_ready  one-hot grant/accept, only in IDLE    [NREQ]
//   xor_a      registered drive to shared gate input A
//   xor_b      registered drive to shared gate input B
//   xor_y      shared gate output
//   rsp_valid  result valid (held until rsp_ready)
//   rsp_y      sampled gate output
//   rsp_id     requester index owning rsp_y          [IDW]
//   rsp_ready  consumer accepts the result
//   busy       high whenever not IDLE
//   op_count   completed responses, wraps            [CNTW]
module xor2_share_arb #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned IDW    = 2,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_a,
  input  logic [NREQ-1:0] req_b,
  output logic [NREQ-1:0] req_ready,
  output logic            xor_a,
  output logic            xor_b,
  input  logic            xor_y,
  output logic            rsp_valid,
  output logic            rsp_y,
  output logic [IDW-1:0]  rsp_id,
  input  logic            rsp_ready,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic            xor_a_q, xor_a_d;
  logic            xor_b_q, xor_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_y_q, rsp_y_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CNTW-1:0] op_count_q, op_count_d;

  // Grant search result
  logic            gnt_any;
  logic [PW-1:0]   gnt_sel;
  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  ptr_nxt;

  // Rotating priority: scan from ptr_q upward, wrapping back to 0.
  always_comb begin
    int unsigned sum;
    gnt_any = 1'b0;
    gnt_sel = '0;
    gnt_oh  = '0;
    sum     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = 32'(ptr_q) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      if (!gnt_any && req_valid[PW'(sum)]) begin
        gnt_any              = 1'b1;
        gnt_sel              = PW'(sum);
        gnt_oh[PW'(sum)]     = 1'b1;
      end
    end
  end

  always_comb begin
    int unsigned nxt;
    nxt = 32'(gnt_sel) + 1;
    if (nxt >= NREQ) nxt = 0;
    ptr_nxt = IDW'(nxt);
  end

  always_comb begin
    state_d     = state_q;
    xor_a_d     = xor_a_q;
    xor_b_d     = xor_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    op_count_d  = op_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          xor_a_d  = req_a[gnt_sel];
          xor_b_d  = req_b[gnt_sel];
          rsp_id_d = IDW'(gnt_sel);
          ptr_d    = ptr_nxt;
          cnt_d    = '0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          rsp_y_d     = xor_y;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      xor_a_q     <= 1'b0;
      xor_b_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= 1'b0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      xor_a_q     <= xor_a_d;
      xor_b_q     <= xor_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      op_count_q  <= op_count_d;
    end
  end

  // State is already IDLE during reset, so rst must mask the grant explicitly.
  assign req_ready = (state_q == S_IDLE && !rst) ? gnt_oh : '0;
  assign busy      = (state_q != S_IDLE);
  assign xor_a     = xor_a_q;
  assign xor_b     = xor_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_xor2_share_arb.sv
// Testbench for xor2_share_arb. Main instance uses default parameters.
// A second small instance (CNTW=2) exercises op_count wrap.
module tb_xor2_share_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid, req_a, req_b, req_ready;
  logic        xor_a, xor_b, xor_y;
  logic        rsp_valid, rsp_y, rsp_ready, busy;
  logic [1:0]  rsp_id;
  logic [15:0] op_count;

  logic [1:0]  w_valid, w_a, w_b, w_ready;
  logic        w_xa, w_xb, w_xy, w_rsp_valid, w_rsp_y, w_busy;
  logic [0:0]  w_rsp_id;
  logic [1:0]  w_op_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  assign xor_y = xor_a ^ xor_b;
  assign w_xy  = w_xa ^ w_xb;

  xor2_share_arb #(.NREQ(4), .IDW(2), .SETTLE(2), .CNTW(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .xor_a(xor_a), .xor_b(xor_b), .xor_y(xor_y),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .busy(busy), .op_count(op_count)
  );

  xor2_share_arb #(.NREQ(2), .IDW(1), .SETTLE(1), .CNTW(2)) u_wrap (
    .clk(clk), .rst(rst),
    .req_valid(w_valid), .req_a(w_a), .req_b(w_b), .req_ready(w_ready),
    .xor_a(w_xa), .xor_b(w_xb), .xor_y(w_xy),
    .rsp_valid(w_rsp_valid), .rsp_y(w_rsp_y), .rsp_id(w_rsp_id), .rsp_ready(1'b1),
    .busy(w_busy), .op_count(w_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Grant must never be multi-hot, and never present outside IDLE or in reset.
  always @(negedge clk) begin
    if (rst) chk("rdy_in_rst", {28'd0, req_ready}, 32'd0);
    else begin
      chk("rdy_onehot", {31'd0, $onehot0(req_ready)}, 32'd1);
      if (busy) chk("rdy_busy", {28'd0, req_ready}, 32'd0);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // One full transaction: wait for a grant, check owner, latency, result,
  // optional backpressure, and the op_count step on handshake.
  task automatic serve_one(input int hold, input int exp_g, input logic exp_y);
    bit got;
    int lat;
    int g;
    logic [3:0] rr;
    rsp_ready = (hold == 0);
    got = 0;
    rr = '0;
    g = -1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready != 4'd0) begin got = 1; rr = req_ready; end
    end
    if (!got) begin chk("grant_timeout", 32'd0, 32'd1); return; end
    for (int i = 0; i < 4; i++) if (rr[i]) g = i;
    chk("grant", g, exp_g);
    @(posedge clk); #1;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    got = 0;
    lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge clk); #1;
      lat = c;
      if (rsp_valid) got = 1;
    end
    if (!got) begin chk("rsp_timeout", 32'd0, 32'd1); return; end
    chk("latency", lat, 2);
    chk("rsp_y", {31'd0, rsp_y}, {31'd0, exp_y});
    chk("rsp_id", {30'd0, rsp_id}, exp_g);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_y", {31'd0, rsp_y}, {31'd0, exp_y});
      chk("bp_id", {30'd0, rsp_id}, exp_g);
      chk("bp_ready", {28'd0, req_ready}, 32'd0);
      chk("bp_count", {16'd0, op_count}, exp_cnt);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt = (exp_cnt + 1) % 65536;
    chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    chk("op_count", {16'd0, op_count}, exp_cnt);
  endtask

  typedef struct {
    bit         rst_first;
    logic [3:0] v;
    logic [3:0] a;
    logic [3:0] b;
    int         hold;
    int         g;
    logic       y;
    int         ptr;
  } vec_t;

  vec_t tv [15];
  int wrap_exp [5];

  initial begin
    bit got;
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    w_valid = '0; w_a = 2'b01; w_b = 2'b00;

    // truth table, requester 0
    tv[0]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 0, 0, 1'b0, 1};
    tv[1]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 1'b1, 1};
    tv[2]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 0, 0, 1'b1, 1};
    tv[3]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 0, 0, 1'b0, 1};
    // round robin, all valid; y per requester = 0,1,1,0
    tv[4]  = '{1'b1, 4'b1111, 4'b0101, 4'b0011, 0, 0, 1'b0, 1};
    tv[5]  = '{1'b0, 4'b1111, 4'b0101, 4'b0011, 0, 1, 1'b1, 2};
    tv[6]  = '{1'b0, 4'b1111, 4'b0101, 4'b0011, 0, 2, 1'b1, 3};
    tv[7]  = '{1'b0, 4'b1111, 4'b0101, 4'b0011, 0, 3, 1'b0, 0};
    tv[8]  = '{1'b0, 4'b1111, 4'b0101, 4'b0011, 0, 0, 1'b0, 1};
    tv[9]  = '{1'b0, 4'b1111, 4'b0101, 4'b0011, 0, 1, 1'b1, 2};
    // backpressure for 5 cycles
    tv[10] = '{1'b0, 4'b1111, 4'b0101, 4'b0011, 5, 2, 1'b1, 3};
    tv[11] = '{1'b0, 4'b1111, 4'b0101, 4'b0011, 0, 3, 1'b0, 0};
    // bring pointer to 2, then only 1 and 3 valid
    tv[12] = '{1'b0, 4'b0010, 4'b0010, 4'b0000, 0, 1, 1'b1, 2};
    tv[13] = '{1'b0, 4'b1010, 4'b1000, 4'b0000, 0, 3, 1'b1, 0};
    tv[14] = '{1'b0, 4'b1010, 4'b1000, 4'b0000, 0, 1, 1'b0, 2};

    wrap_exp = '{1, 2, 3, 0, 1};

    // reset values
    #1;
    chk("rst_xor_a", {31'd0, xor_a}, 32'd0);
    chk("rst_xor_b", {31'd0, xor_b}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_y", {31'd0, rsp_y}, 32'd0);
    chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      if (tv[i].rst_first) do_reset();
      req_valid = tv[i].v;
      req_a     = tv[i].a;
      req_b     = tv[i].b;
      serve_one(tv[i].hold, tv[i].g, tv[i].y);
      chk("ptr", {30'd0, dut.ptr_q}, tv[i].ptr);
      if (i == 3) begin
        chk("tt_op_count", {16'd0, op_count}, 32'd4);
        // gate drive and pointer hold while idle with new (unrequested) operands
        req_valid = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_xor_a", {31'd0, xor_a}, 32'd1);
        chk("idle_xor_b", {31'd0, xor_b}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ptr", {30'd0, dut.ptr_q}, 32'd1);
      end
    end

    // async reset mid-SETTLE (pointer is 2 here)
    req_valid = 4'b0100; req_a = 4'b0100; req_b = 4'b0000;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready != 4'd0) got = 1;
    end
    if (!got) chk("ar_grant_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    chk("ar_busy", {31'd0, busy}, 32'd1);
    chk("ar_xor_a", {31'd0, xor_a}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_busy0", {31'd0, busy}, 32'd0);
    chk("ar_xor_a0", {31'd0, xor_a}, 32'd0);
    chk("ar_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("ar_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("ar_op_count", {16'd0, op_count}, 32'd0);
    chk("ar_ready", {28'd0, req_ready}, 32'd0);
    chk("ar_ptr", {30'd0, dut.ptr_q}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    chk("ar_no_rsp", {31'd0, rsp_valid}, 32'd0);
    req_valid = 4'b0101; req_a = 4'b0101; req_b = 4'b0000;
    serve_one(0, 0, 1'b1);
    serve_one(0, 2, 1'b1);
    req_valid = '0;

    // op_count wrap on CNTW=2 instance
    w_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        if (w_rsp_valid) got = 1;
      end
      if (!got) chk("wrap_timeout", 32'd0, 32'd1);
      chk("wrap_y", {31'd0, w_rsp_y}, 32'd1);
      @(posedge clk); #1;
      chk("wrap_count", {30'd0, w_op_count}, wrap_exp[k]);
    end
    w_valid = '0;

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

endmodule
